// File: rtl/vga_text_overlay_pkg.sv
// Shared constants for the VGA text overlay: text window geometry, glyph
// codes understood by the font ROM, default colours and the swap-handshake
// state type.
package vga_text_overlay_pkg;

    // Text window: 16 columns x 4 rows of 8x16-pixel cells.
    localparam int unsigned TXT_COLS = 16;
    localparam int unsigned TXT_ROWS = 4;
    localparam int unsigned CELL_W   = 8;
    localparam int unsigned CELL_H   = 16;
    localparam int unsigned WIN_W    = TXT_COLS * CELL_W;   // 128 pixels
    localparam int unsigned WIN_H    = TXT_ROWS * CELL_H;   // 64 lines
    localparam int unsigned CELLS    = TXT_COLS * TXT_ROWS; // 64 cells per buffer

    // Glyph codes; 0-9 are the digits themselves.
    localparam logic [3:0] GLYPH_COLON = 4'hA;
    localparam logic [3:0] GLYPH_DASH  = 4'hB;
    localparam logic [3:0] GLYPH_A     = 4'hC;
    localparam logic [3:0] GLYPH_P     = 4'hD;
    localparam logic [3:0] GLYPH_M     = 4'hE;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // Default colours, {R4,G4,B4}.
    localparam logic [11:0] FG_DEFAULT     = 12'hFFF;
    localparam logic [11:0] BG_DEFAULT     = 12'h00F;
    localparam logic [11:0] OUT_BG_DEFAULT = 12'h000;

    // Front/back swap handshake.
    typedef enum logic {
        SWAP_IDLE,
        SWAP_PEND
    } swap_state_e;

endpackage

// File: rtl/vga_text_overlay_font_rom.sv
// 8x16 glyph ROM for the text overlay: 16 glyphs x 16 lines = 256 bytes.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (row clears to 0)
//   p_tick     : clock enable; the output row updates only on enabled edges
//   addr       : {glyph code[3:0], glyph line[3:0]}
//   row        : registered 8-bit glyph line, bit 7 = leftmost pixel
module font_rom
    import vga_text_overlay_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [7:0] addr,
    output logic [7:0] row
);

    // One glyph as 16 bytes, line 0 in the top byte.
    logic [127:0] glyph;
    logic [6:0]   base;
    logic [7:0]   row_next;

    always_comb begin
        glyph = '0;
        unique case (addr[7:4])
            4'h0:        glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            4'h1:        glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            4'h2:        glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            4'h3:        glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            4'h4:        glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            4'h5:        glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            4'h6:        glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            4'h7:        glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            4'h8:        glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            4'h9:        glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            GLYPH_COLON: glyph = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
            GLYPH_DASH:  glyph = 128'h0000_0000_0000_00FE_0000_0000_0000_0000;
            GLYPH_A:     glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
            GLYPH_P:     glyph = 128'h0000_FC66_6666_7C60_6060_60F0_0000_0000;
            GLYPH_M:     glyph = 128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_0000_0000;
            GLYPH_BLANK: glyph = '0;
        endcase
        // Top bit of line L is 127 - 8*L, which in 7 bits is ~{L,3'b000}.
        base     = {~addr[3:0], 3'b111};
        row_next = glyph[base -: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
        end else if (p_tick) begin
            row <= row_next;
        end
    end

endmodule

// File: rtl/vga_text_overlay.sv
// Text overlay pixel stage placed after the VGA sync generator. Renders a
// 16x4 window of 8x16 glyphs from a double-buffered character store and
// emits registered RGB with hsync/vsync delayed to match the 3-stage pipeline.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   p_tick              : pixel enable; all pipeline stages advance on it
//   pixel_x, pixel_y    : current pixel coordinates from the sync generator
//   video_on            : visible-area flag
//   hsync_i, vsync_i    : syncs from the generator
//   wr_en/addr/data     : back-buffer write port (addr = row*16 + col)
//   swap_req            : request a front/back exchange at line VD, column 0
//   swap_ack, swap_pend : commit pulse / request outstanding
//   rgb                 : pixel colour {R4,G4,B4}
//   hsync_o, vsync_o    : syncs delayed 3 pixel ticks
module vga_text_overlay
    import vga_text_overlay_pkg::*;
#(
    parameter int unsigned X0     = 256,
    parameter int unsigned Y0     = 208,
    parameter int unsigned VD     = 480,
    parameter logic [11:0] FG     = FG_DEFAULT,
    parameter logic [11:0] BG     = BG_DEFAULT,
    parameter logic [11:0] OUT_BG = OUT_BG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        swap_pend,
    output logic [11:0] rgb,
    output logic        hsync_o,
    output logic        vsync_o
);

    // ---------------- character store and swap handshake ----------------
    // Both buffers in one array: index = {buffer, cell}.
    logic [3:0]  char_mem [0:2*CELLS-1];
    logic        front_sel;
    swap_state_e swap_state, swap_next;
    logic        commit;

    always_comb begin
        swap_next = swap_state;
        commit    = 1'b0;
        unique case (swap_state)
            SWAP_IDLE: begin
                if (swap_req) swap_next = SWAP_PEND;
            end
            SWAP_PEND: begin
                if (p_tick && pixel_x == 10'd0 && pixel_y == 10'(VD)) begin
                    commit    = 1'b1;
                    // A request arriving on the commit clock queues the next swap.
                    swap_next = swap_req ? SWAP_PEND : SWAP_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_state <= SWAP_IDLE;
            front_sel  <= 1'b0;
            swap_ack   <= 1'b0;
        end else begin
            swap_state <= swap_next;
            swap_ack   <= commit;
            if (commit) front_sel <= ~front_sel;
        end
    end

    assign swap_pend = (swap_state == SWAP_PEND);

    // Writes use the pre-toggle select, so a write on the commit clock
    // lands in the buffer that becomes front.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2 * CELLS; i++) char_mem[i] <= GLYPH_BLANK;
        end else if (wr_en) begin
            char_mem[{~front_sel, wr_addr}] <= wr_data;
        end
    end

    // ---------------- window geometry ----------------
    // 11-bit differences: bit 10 set means the pixel is left of / above the window.
    logic [10:0] dx, dy;
    logic        in_win;
    logic [5:0]  cell_addr;

    always_comb begin
        dx        = {1'b0, pixel_x} - 11'(X0);
        dy        = {1'b0, pixel_y} - 11'(Y0);
        in_win    = !dx[10] && (dx < 11'(WIN_W)) && !dy[10] && (dy < 11'(WIN_H));
        cell_addr = {dy[5:4], dx[6:3]};
    end

    // ---------------- S1: character fetch ----------------
    logic [3:0] s1_code, s1_line;
    logic [2:0] s1_bit;
    logic       s1_win, s1_von, s1_hs, s1_vs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_code <= '0;
            s1_line <= '0;
            s1_bit  <= '0;
            s1_win  <= 1'b0;
            s1_von  <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
        end else if (p_tick) begin
            s1_code <= char_mem[{front_sel, cell_addr}];
            s1_line <= dy[3:0];
            s1_bit  <= 3'd7 - dx[2:0];
            s1_win  <= in_win;
            s1_von  <= video_on;
            s1_hs   <= hsync_i;
            s1_vs   <= vsync_i;
        end
    end

    // ---------------- S2: font lookup ----------------
    logic [7:0] font_row;
    logic [2:0] s2_bit;
    logic       s2_win, s2_von, s2_hs, s2_vs;

    font_rom u_font_rom (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick),
        .addr   ({s1_code, s1_line}),
        .row    (font_row)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_bit <= '0;
            s2_win <= 1'b0;
            s2_von <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
        end else if (p_tick) begin
            s2_bit <= s1_bit;
            s2_win <= s1_win;
            s2_von <= s1_von;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
        end
    end

    // ---------------- S3: colour select ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb     <= '0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
        end else if (p_tick) begin
            if (!s2_von)                rgb <= '0;
            else if (!s2_win)           rgb <= OUT_BG;
            else if (font_row[s2_bit])  rgb <= FG;
            else                        rgb <= BG;
            hsync_o <= s2_hs;
            vsync_o <= s2_vs;
        end
    end

endmodule

// File: tb/tb_vga_text_overlay.sv
module tb_vga_text_overlay;

    localparam logic [11:0] C_FG  = 12'hFFF;
    localparam logic [11:0] C_BG  = 12'h00F;
    localparam logic [11:0] C_OUT = 12'h000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic [9:0]  pixel_x = 10'd300;
    logic [9:0]  pixel_y = 10'd220;
    logic        video_on = 1'b1;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        swap_pend;
    logic [11:0] rgb;
    logic        hsync_o;
    logic        vsync_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] font_one   [16] = '{8'h00, 8'h00, 8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18,
                                    8'h18, 8'h18, 8'h18, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] font_eight [16] = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'hC6,
                                    8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] font_a     [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_rows   [16];

    vga_text_overlay dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .hsync_i   (hsync_i),
        .vsync_i   (vsync_i),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .swap_pend (swap_pend),
        .rgb       (rgb),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One enabled clock followed by one idle clock.
    task automatic tick();
        p_tick = 1'b1;
        step();
        p_tick = 1'b0;
        step();
    endtask

    // Hold a pixel for three ticks so it reaches the output register.
    task automatic show(input int x, input int y, input logic von);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        repeat (3) tick();
    endtask

    task automatic check_pix(input string tag, input int x, input int y, input logic [11:0] exp);
        show(x, y, 1'b1);
        check($sformatf("%s(%0d,%0d)", tag, x, y), 32'(rgb), 32'(exp));
    endtask

    task automatic check_glyph(input string tag, input int x0, input int y0);
        for (int l = 0; l < 16; l++) begin
            for (int c = 0; c < 8; c++) begin
                logic [7:0] r;
                r = exp_rows[l];
                check_pix(tag, x0 + c, y0 + l, r[7 - c] ? C_FG : C_BG);
            end
        end
    endtask

    task automatic write_cell(input int addr, input logic [3:0] code);
        wr_addr = 6'(addr);
        wr_data = code;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_req();
        pixel_x  = 10'd10;
        pixel_y  = 10'd100;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    // Enabled clock at (0,VD): checks the ack pulse and the pending flag after it.
    task automatic commit_tick(input string tag, input logic exp_ack, input logic exp_pend);
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        p_tick  = 1'b1;
        step();
        check({tag, "_ack"}, 32'(swap_ack), 32'(exp_ack));
        check({tag, "_pend"}, 32'(swap_pend), 32'(exp_pend));
        p_tick   = 1'b0;
        swap_req = 1'b0;
        wr_en    = 1'b0;
        step();
        check({tag, "_ack_drop"}, 32'(swap_ack), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h0, h1, e, cur;

        // ---- reset state, including ticks while held in reset ----
        repeat (3) step();
        p_tick = 1'b1;
        repeat (2) step();
        p_tick = 1'b0;
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_hs", 32'(hsync_o), 32'd0);
        check("rst_vs", 32'(vsync_o), 32'd0);
        check("rst_pend", 32'(swap_pend), 32'd0);
        check("rst_ack", 32'(swap_ack), 32'd0);
        reset = 1'b0;
        step();

        // ---- blank buffers after reset ----
        check_pix("blank_tl", 256, 208, C_BG);
        check_pix("blank_br", 383, 271, C_BG);
        check_pix("blank_mid", 300, 240, C_BG);
        check_pix("outside", 0, 0, C_OUT);
        check_pix("outside", 639, 479, C_OUT);
        check_pix("left_edge", 255, 208, C_OUT);
        check_pix("top_edge", 256, 207, C_OUT);
        show(300, 240, 1'b0);
        check("blanking_in_win", 32'(rgb), 32'd0);
        show(700, 500, 1'b0);
        check("blanking", 32'(rgb), 32'd0);

        // ---- outputs hold without p_tick ----
        show(256, 208, 1'b1);
        pixel_x  = 10'd0;
        pixel_y  = 10'd0;
        video_on = 1'b0;
        repeat (4) step();
        check("hold_rgb", 32'(rgb), 32'(C_BG));

        // ---- hsync latency around x=656 ----
        pixel_y = 10'd10;
        h0 = 1'b1;
        h1 = 1'b1;
        for (int x = 650; x <= 662; x++) begin
            pixel_x = 10'(x);
            cur     = (x >= 656) ? 1'b0 : 1'b1;
            hsync_i = cur;
            p_tick  = 1'b1;
            step();
            e = h1;
            check($sformatf("hs_lat_x%0d", x), 32'(hsync_o), 32'(e));
            h1 = h0;
            h0 = cur;
            p_tick = 1'b0;
            step();
            check($sformatf("hs_hold_x%0d", x), 32'(hsync_o), 32'(e));
        end
        hsync_i = 1'b1;

        // ---- vsync latency around y=490 ----
        pixel_x = 10'd0;
        h0 = 1'b1;
        h1 = 1'b1;
        for (int y = 487; y <= 494; y++) begin
            pixel_y = 10'(y);
            cur     = (y == 490 || y == 491) ? 1'b0 : 1'b1;
            vsync_i = cur;
            p_tick  = 1'b1;
            step();
            e = h1;
            check($sformatf("vs_lat_y%0d", y), 32'(vsync_o), 32'(e));
            h1 = h0;
            h0 = cur;
            p_tick = 1'b0;
            step();
        end
        vsync_i = 1'b1;
        show(10, 10, 1'b0);
        check("vs_settled", 32'(vsync_o), 32'd1);

        // ---- first swap: '1' into cell 0 ----
        write_cell(0, 4'h1);
        pulse_req();
        check("swap1_pend", 32'(swap_pend), 32'd1);
        check_pix("swap1_old_buf", 259, 210, C_BG);
        check("swap1_still_pend", 32'(swap_pend), 32'd1);
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        step();
        check("no_commit_without_tick", 32'(swap_ack), 32'd0);
        pixel_x = 10'd1;
        p_tick  = 1'b1;
        step();
        check("no_commit_x1", 32'(swap_ack), 32'd0);
        p_tick = 1'b0;
        step();
        check("pend_before_commit", 32'(swap_pend), 32'd1);
        commit_tick("swap1", 1'b1, 1'b0);
        exp_rows = font_one;
        check_glyph("glyph_one", 256, 208);
        check_pix("left_of_win", 255, 208, C_OUT);
        check_pix("right_of_win", 384, 208, C_OUT);

        // ---- second swap: '8' into last cell, duplicate requests absorbed ----
        write_cell(63, 4'h8);
        pulse_req();
        step();
        pulse_req();
        check("swap2_pend", 32'(swap_pend), 32'd1);
        check_pix("swap2_old_8", 377, 258, C_BG);
        check_pix("swap2_old_1", 259, 210, C_FG);
        commit_tick("swap2", 1'b1, 1'b0);
        commit_tick("no_extra_swap", 1'b0, 1'b0);
        exp_rows = font_eight;
        check_glyph("glyph_eight", 376, 256);
        check_pix("corner_right", 384, 271, C_OUT);
        check_pix("corner_below", 376, 272, C_OUT);
        check_pix("cell0_now_blank", 259, 210, C_BG);

        // ---- request held across commit plus write on commit clock ----
        swap_req = 1'b1;
        step();
        check("swap3_pend", 32'(swap_pend), 32'd1);
        wr_en   = 1'b1;
        wr_addr = 6'd5;
        wr_data = 4'hC;
        commit_tick("swap3", 1'b1, 1'b1);
        check("swap3_pend_after", 32'(swap_pend), 32'd1);
        exp_rows = font_a;
        check_glyph("glyph_a", 296, 208);
        check_pix("swap3_cell0", 259, 210, C_FG);
        commit_tick("swap4", 1'b1, 1'b0);
        check_pix("swap4_8_back", 377, 258, C_FG);

        // ---- reset mid-line drops a pending swap ----
        pulse_req();
        check("pre_rst_pend", 32'(swap_pend), 32'd1);
        show(377, 258, 1'b1);
        check("pre_rst_rgb", 32'(rgb), 32'(C_FG));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_rgb", 32'(rgb), 32'd0);
        check("midrst_pend", 32'(swap_pend), 32'd0);
        check("midrst_hs", 32'(hsync_o), 32'd0);
        check("midrst_vs", 32'(vsync_o), 32'd0);
        step();
        reset = 1'b0;
        step();
        check_pix("post_rst_blank", 377, 258, C_BG);
        check_pix("post_rst_cell0", 259, 210, C_BG);
        commit_tick("post_rst", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
